mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory responder: the memory side of the pipeline's data-memory access interface.
- Accepts one load/store request at a time from the MEM stage and holds the requester with `stall` for a fixed, parameterised access latency.
- On completion it returns read data, or commits the write, and pulses `done` for one cycle.
- Replaces the single-cycle memory model so that later work on the pipeline's stall handling and cache has a realistic multi-cycle target.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, byte-address width in bits.
- DEPTH_LOG2, 10, log2 of the number of words in the storage array.
- LATENCY, 4, number of BUSY cycles per access; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; qualifies addr, wr and data_in.
- wr  in  1  1 = store, 0 = load; sampled only when a request is accepted.
- addr  in  ADDR_W  byte address.
- data_in  in  DATA_W  store data.
- data_out  out  DATA_W  load data; valid while done=1 and held afterwards.
- stall  out  1  requester must hold its request and freeze upstream stages.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned-access flag; valid with done.

Behaviour:
- Reset:
  - Asynchronous, active-low: reset is asserted when rst=0 and takes effect immediately, independent of clk.
  - State = IDLE; count = 0; data_out = 0; done = 0; err = 0.
  - The stall output follows its equation; with state IDLE it equals req.
  - Storage array contents are not reset.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - When req=1, latch addr, wr and data_in; set count = LATENCY-1; go to BUSY.
  - When req=0, remain in IDLE.
- BUSY:
  - When count != 0, decrement count.
  - When count == 0, perform the access and go to DONE.
- Access (in the last BUSY cycle, registered at the edge):
  - Word index = latched addr[DEPTH_LOG2:1]. Higher address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
  - Store: write the latched data_in to array[index]; data_out keeps its previous value.
  - Load: data_out = array[index].
  - Misaligned (latched addr[0]=1): no array write; data_out = 0; err = 1.
- DONE:
  - done = 1 for exactly this one cycle; err is valid in the same cycle.
  - req is ignored; next state is always IDLE.
  - This gives one bubble cycle between back-to-back requests.
- stall = (state==IDLE & req) | (state==BUSY). Combinational from req and state; 0 in DONE.
- Timing: a request first seen in IDLE in cycle T gives:
  - stall high in cycles T through T+LATENCY (LATENCY+1 cycles);
  - BUSY in cycles T+1 through T+LATENCY;
  - done in cycle T+LATENCY+1.
- The requester must hold req, wr, addr and data_in stable while stall=1. Changes during BUSY are ignored because the values were latched at acceptance.
- done and err clear to 0 on the cycle after DONE.
- data_out holds its last load result, or 0 after a misaligned access, until the next completed access.
- Reset mid-operation (BUSY or DONE): the access is abandoned and any pending store is not written. After release the block is in IDLE and can accept a request on the next edge.
- Write-then-read to the same address always returns the new data, because accesses are strictly serialised.

Test Plan:
1. Reset, then store 0xBEEF to 0x0010, then load 0x0010 -> store done at T+5 (LATENCY=4); load done with data_out=0xBEEF, err=0.
2. Single load with req held -> stall high for exactly 5 cycles, done high in exactly 1 cycle (the 6th), state back in IDLE after DONE.
3. Load from 0x0011 (misaligned), after a prior store of 0x1234 to 0x0010 -> done=1, err=1, data_out=0; a later load of 0x0010 still returns 0x1234.
4. Store 0x5555 to 0x0004; pull rst low during the 2nd BUSY cycle; release; load 0x0004 -> previous contents returned, not 0x5555; outputs 0 while rst=0.
5. Two back-to-back requests with req held continuously -> first done at T+5; req ignored in DONE; second accepted at T+6 and done at T+11.
6. Store 0xA5A5 to 0x0806 (DEPTH_LOG2=10); load 0x0006 -> data_out=0xA5A5 (address aliasing).

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output req, wr, addr, data_in,
    input  data_out, stall, done, err
  );

  modport slave (
    input  req, wr, addr, data_in,
    output data_out, stall, done, err
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one access at a time, stalls the
// requester for LATENCY busy cycles, then pulses done with read data / err.
//
// state | meaning
// IDLE  | waiting for req; stall mirrors req
// BUSY  | access in flight, count runs down to 0; access happens on the last cycle
// DONE  | one-cycle completion pulse; req ignored, always returns to IDLE
module mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH_LOG2:0]   addr_q;
  logic                  wr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     data_out_q;
  logic                  err_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  access;
  logic [DEPTH_LOG2-1:0] idx;

  // Address bits above the word index only alias, so they are never stored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2+1];

  assign access = (state_q == BUSY) && (count_q == '0);
  assign idx    = addr_q[DEPTH_LOG2:1];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = BUSY;
      BUSY:    if (count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; stall is combinational from req in IDLE.
  always_comb begin
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE:    bus.stall = bus.req;
      BUSY:    bus.stall = 1'b1;
      DONE:    bus.done  = 1'b1;
      default: ;
    endcase
  end

  // Latency down-counter: loaded on acceptance, runs to terminal count in BUSY.
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && bus.req)            count_d = CNT_W'(LATENCY - 1);
    else if (state_q == BUSY && count_q != '0) count_d = count_q - 1'b1;
  end

  // Request latch, counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      if (state_q == IDLE && bus.req) begin
        addr_q  <= bus.addr[DEPTH_LOG2:0];
        wr_q    <= bus.wr;
        wdata_q <= bus.data_in;
      end
      if (access) begin
        if (addr_q[0]) begin
          err_q      <= 1'b1;
          data_out_q <= '0;
        end else if (!wr_q) begin
          data_out_q <= mem_q[idx];
        end
      end
      if (state_q == DONE) err_q <= 1'b0;
    end
  end

  // Storage array write; contents survive reset. A reset forces IDLE, so an
  // abandoned store never reaches this point.
  always_ff @(posedge clk) begin
    if (access && wr_q && !addr_q[0]) mem_q[idx] <= wdata_q;
  end

  assign bus.data_out = data_out_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] d;
    logic        e;
    bit          chk_d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_err", {31'd0, bus.err}, {31'd0, e.e});
          if (e.chk_d) check("resp_data", {16'd0, bus.data_out}, {16'd0, e.d});
        end
      end
    end
  end

  function automatic void expect_resp(input logic [15:0] d, input logic e, input bit chk_d);
    exp_t x;
    x.d = d; x.e = e; x.chk_d = chk_d;
    sb.push_back(x);
  endfunction

  // One access with req held until done; checks stall length and done position.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_d, input logic exp_e, input bit chk_d);
    int cyc;
    int stall_cnt;
    bit seen;
    expect_resp(exp_d, exp_e, chk_d);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.data_in = d;
    cyc = 0; stall_cnt = 0; seen = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.stall) stall_cnt++;
      if (bus.done) seen = 1;
    end
    bus.req = 1'b0;
    check("done_cycle", cyc, 6);
    check("stall_cycles", stall_cnt, 5);
    @(negedge clk);
    check("done_cleared", {31'd0, bus.done}, 32'd0);
    check("err_cleared", {31'd0, bus.err}, 32'd0);
    check("idle_stall", {31'd0, bus.stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int done_at[$];
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;

    // Reset values; stall tracks req asynchronously while in reset.
    #12;
    check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_stall_req0", {31'd0, bus.stall}, 32'd0);
    bus.req = 1'b1; #1;
    check("rst_stall_req1", {31'd0, bus.stall}, 32'd1);
    bus.req = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Store then load.
    access(1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 0);
    access(1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 1);

    // Misaligned load, then aligned load still sees the stored word.
    access(1'b1, 16'h0010, 16'h1234, 16'h0, 1'b0, 0);
    access(1'b0, 16'h0011, 16'h0, 16'h0000, 1'b1, 1);
    access(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 1);

    // Misaligned store must not write.
    access(1'b1, 16'h0012, 16'h2222, 16'h0, 1'b0, 0);
    access(1'b1, 16'h0013, 16'h7777, 16'h0, 1'b1, 0);
    access(1'b0, 16'h0012, 16'h0, 16'h2222, 1'b0, 1);

    // Reset during second BUSY cycle abandons the store.
    access(1'b1, 16'h0004, 16'h1111, 16'h0, 1'b0, 0);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0004; bus.data_in = 16'h5555;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0; bus.req = 1'b0;
    #1;
    check("midrst_data_out", {16'd0, bus.data_out}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_err", {31'd0, bus.err}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); @(negedge clk);
    check("midrst_done_held", {31'd0, bus.done}, 32'd0);
    rst = 1'b1;
    access(1'b0, 16'h0004, 16'h0, 16'h1111, 1'b0, 1);

    // Back-to-back loads with req held: done at T+5 and T+11, no stall in DONE.
    expect_resp(16'h1234, 1'b0, 1);
    expect_resp(16'h1234, 1'b0, 1);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0010;
    cyc = 0;
    while (done_at.size() < 2 && cyc < 60) begin
      @(negedge clk);
      if (bus.done) begin
        done_at.push_back(cyc);
        check("b2b_stall_in_done", {31'd0, bus.stall}, 32'd0);
      end
      cyc++;
    end
    bus.req = 1'b0;
    check("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b_first_done", done_at[0], 5);
      check("b2b_second_done", done_at[1], 11);
    end

    // Address aliasing: 0x0806 and 0x0006 share word index 3.
    access(1'b1, 16'h0806, 16'hA5A5, 16'h0, 1'b0, 0);
    access(1'b0, 16'h0006, 16'h0, 16'hA5A5, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
